// File: rtl/mram_pwr_seq_monitor.sv
// mram_pwr_seq_monitor: tracks MRAM rail/control ordering, raises ready after a legal power-up, flags violations.
// Optional stall timeout enabled by defining MRAM_SEQ_MON_TIMEOUT_EN.
module mram_pwr_seq_monitor #(
    parameter int MIN_STEP_CYC = 1,
    parameter int CNT_W        = 8,
    parameter int TIMEOUT_CYC  = 200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vdd_i,
    input  logic             vdda_i,
    input  logic             vref_i,
    input  logic             porb_i,
    input  logic             retb_i,
    input  logic             rstb_i,
    input  logic             trim_i,
    input  logic             dpd_i,
    input  logic             ceb_high_i,
    input  logic             isolate_i,
    input  logic             clear_err_i,
    output logic             ready_o,
    output logic             err_o,
    output logic [2:0]       err_code_o,
    output logic [3:0]       step_o,
    output logic [CNT_W-1:0] pu_cycles_o
);
    typedef enum logic [3:0] {
        S_OFF, S_VDD, S_VDDA, S_VREF, S_PORRET, S_RST, S_ISO, S_TRIM, S_TRIMD,
        S_READY, S_CE_OFF, S_DPD, S_ERR = 4'd15
    } state_e;

    localparam logic [9:0] B_VDD = 10'h200, B_VDDA = 10'h100, B_VREF = 10'h080, B_PORB = 10'h040;
    localparam logic [9:0] B_RETB = 10'h020, B_RSTB = 10'h010, B_TRIM = 10'h008, B_DPD = 10'h004;
    localparam logic [9:0] B_CEB = 10'h002, B_ISO = 10'h001, OFF_PAT = B_DPD | B_CEB | B_ISO;

    state_e           state_q, state_d, fwd_s, bwd_s;
    logic [9:0]       cur, chg, prev_q, fwd_m, fwd_v, bwd_m, bwd_v;
    logic [CNT_W-1:0] dwell_q, dwell_d, pu_q, pu_d;
    logic [2:0]       code_q, code_d, viol;
    logic             run_q, run_d, first_q, err_q, err_d, ready_q;
    logic             leg_f, leg_b, legal, too_fast, stall_to;

    assign cur = {vdd_i, vdda_i, vref_i, porb_i, retb_i, rstb_i, trim_i, dpd_i, ceb_high_i, isolate_i};
    assign chg = (cur ^ prev_q) & ~((state_q == S_CE_OFF) ? 10'h000 : B_DPD);

    // One forward event per state; VDD..ISO also accept the exact reverse of the step that entered them.
    always_comb begin
        fwd_m = '0;
        fwd_v = '0;
        fwd_s = S_ERR;
        bwd_m = '0;
        bwd_v = '0;
        bwd_s = S_ERR;
        case (state_q)
            S_OFF:    begin fwd_m = B_VDD;  fwd_v = B_VDD;  fwd_s = S_VDD; end
            S_VDD:    begin fwd_m = B_VDDA; fwd_v = B_VDDA; fwd_s = S_VDDA; bwd_m = B_VDD; bwd_s = S_OFF; end
            S_VDDA:   begin fwd_m = B_VREF; fwd_v = B_VREF; fwd_s = S_VREF; bwd_m = B_VDDA; bwd_s = S_VDD; end
            S_VREF:   begin fwd_m = B_PORB | B_RETB; fwd_v = fwd_m; fwd_s = S_PORRET; bwd_m = B_VREF; bwd_s = S_VDDA; end
            S_PORRET: begin fwd_m = B_RSTB; fwd_v = B_RSTB; fwd_s = S_RST; bwd_m = B_PORB | B_RETB; bwd_s = S_VREF; end
            S_RST:    begin fwd_m = B_ISO; fwd_s = S_ISO; bwd_m = B_RSTB; bwd_s = S_PORRET; end
            S_ISO:    begin fwd_m = B_TRIM; fwd_v = B_TRIM; fwd_s = S_TRIM; bwd_m = B_ISO; bwd_v = B_ISO; bwd_s = S_RST; end
            S_TRIM:   begin fwd_m = B_TRIM; fwd_s = S_TRIMD; end
            S_TRIMD:  begin fwd_m = B_CEB; fwd_s = S_READY; end
            S_READY:  begin fwd_m = B_CEB; fwd_v = B_CEB; fwd_s = S_CE_OFF; end
            S_CE_OFF: begin fwd_m = B_DPD; fwd_v = B_DPD; fwd_s = S_DPD; end
            S_DPD:    begin fwd_m = B_ISO; fwd_v = B_ISO; fwd_s = S_RST; end
            default:  ;
        endcase
    end

    assign leg_f    = (fwd_m != '0) && (chg == fwd_m) && ((cur & fwd_m) == fwd_v);
    assign leg_b    = (bwd_m != '0) && (chg == bwd_m) && ((cur & bwd_m) == bwd_v);
    assign legal    = leg_f | leg_b;
    assign too_fast = legal && (({1'b0, dwell_q} + 1'b1) < (CNT_W + 1)'(MIN_STEP_CYC));
    assign viol     = (first_q && |cur[9:7]) ? 3'd3 : too_fast ? 3'd2 :
                      (|chg && !legal) ? 3'd1 : stall_to ? 3'd4 : 3'd0;

`ifdef MRAM_SEQ_MON_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall_q;
    logic          stall_run;
    assign stall_run = !(state_q inside {S_OFF, S_READY, S_ERR});
    assign stall_to  = stall_run && !legal && (stall_q == SW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= (stall_run && !legal && !clear_err_i) ? stall_q + 1'b1 : '0;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign stall_to       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        code_d  = code_q;
        dwell_d = legal ? '0 : (&dwell_q ? dwell_q : dwell_q + 1'b1);
        if (clear_err_i) begin
            state_d = S_OFF;
            err_d   = 1'b0;
            code_d  = 3'd0;
            dwell_d = '1;
        end else if (state_q != S_ERR) begin
            if (viol != 3'd0) begin
                state_d = S_ERR;
                err_d   = 1'b1;
                code_d  = viol;
            end else if (leg_f) state_d = fwd_s;
            else if (leg_b) state_d = bwd_s;
        end
        // pu_cycles only runs on a power-up started by a vdd rise from OFF; it freezes on leaving VDD..TRIMD.
        run_d = (state_d inside {[S_VDD:S_TRIMD]}) && (run_q || state_q == S_OFF);
        pu_d  = run_q ? (&pu_q ? pu_q : pu_q + 1'b1) : pu_q;
        if ((state_q == S_OFF && state_d == S_VDD) || (run_q && state_d == S_OFF)) pu_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_OFF;
            prev_q  <= OFF_PAT;
            first_q <= 1'b1;
            dwell_q <= '1;
            pu_q    <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= cur;
            first_q <= 1'b0;
            dwell_q <= dwell_d;
            pu_q    <= pu_d;
            run_q   <= run_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ready_q <= (state_d == S_READY);
        end
    end

    assign ready_o     = ready_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign step_o      = state_q;
    assign pu_cycles_o = pu_q;
endmodule
